ysyx_22041752_wbu_multi: RTL and testbench
==========================================

Name: ysyx_22041752_wbu_multi

Overview:
Parametrised multi-lane write-back stage; next generation of the single-lane WBU.
- Accepts a bundle of up to LANES results from the MEM stage through the valid/allowin handshake.
- Commits the bundle to a register file with RF_WPORTS write ports, serialising over several cycles when the bundle needs more writes than there are ports.
- Exports per-lane forwarding and a retired-instruction counter.

Parameters:
LANES, 2, number of result lanes per bundle (1..4)
RF_WPORTS, 1, number of register-file write ports (1..LANES)
RF_ADDR_WD, 5, register index width
RF_DATA_WD, 64, register data width
PC_WD, 64, program-counter width

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-low reset; all state clears while low
ws_allowin  output  1  stage can accept a bundle this cycle
ms_to_ws_valid  input  LANES  per-lane valid; lanes are contiguous from lane 0
ms_to_ws_bus  input  LANES*(1+RF_ADDR_WD+RF_DATA_WD+PC_WD)  lane i at [i*LW +: LW]; lane layout {we, rd, data, pc}
ws_to_rf_bus  output  RF_WPORTS*(1+RF_ADDR_WD+RF_DATA_WD)  port p at [p*PW +: PW]; port layout {we, waddr, wdata}
ws_forward_bus  output  LANES*(1+RF_DATA_WD+RF_ADDR_WD)  lane i at [i*FW +: FW]; lane layout {valid, data, rd}
ws_retire_cnt  output  64  count of retired instructions

Behaviour:
Storage
- ws_valid, lane_valid[LANES] and the bundle register are captured on a clk edge when (|ms_to_ws_valid) && ws_allowin.

Pending mask (computed at capture)
- pend[i] = lane valid && we && rd != 0.
- Same-rd conflict: pend[i] is also cleared if any higher lane j > i in the bundle has pend[j] set with the same rd. The youngest write wins, and no RF port ever sees duplicate addresses.

Commit
- Each cycle with ws_valid, the lowest-indexed min(RF_WPORTS, popcount(pend)) pending lanes drive ports 0.. in ascending lane order.
- Those lanes' pend bits clear at the clk edge.
- Unused ports have we = 0; waddr and wdata are don't-care.

Handshake
- ws_ready_go = popcount(pend) <= RF_WPORTS, i.e. the bundle finishes this cycle.
- ws_allowin = !ws_valid || ws_ready_go.
- ws_valid is updated only when ws_allowin: it takes |ms_to_ws_valid.

Latency
- A bundle occupies ceil(k/RF_WPORTS) cycles, where k = number of pending writes; minimum 1 cycle (k = 0 still takes 1 cycle).
- Back-to-back bundles are accepted with no bubble when each needs at most RF_WPORTS writes.

Forwarding
- valid_i = ws_valid && lane_valid[i] && we_i && rd_i != 0, for every lane, including lanes already written and lanes suppressed by a conflict. Held for the bundle's whole residency.
- Priority between lanes with equal rd belongs to the consumer; higher lane is younger.

Retire counter
- Increments by popcount(lane_valid) on the completion cycle (ws_valid && ws_ready_go).
- 64-bit, wraps modulo 2^64.

Reset
- Asynchronous, active-low: ws_valid = 0, pend = 0, lane_valid = 0, ws_retire_cnt = 0.
- Consequently ws_allowin = 1, all RF we = 0 and all forward valid = 0 while reset is low and after release.
- Bundle data register is not reset.
- Reset during a serialised commit abandons the remaining writes; the counter is not incremented.

Illegal input
- Non-contiguous ms_to_ws_valid is illegal; behaviour is undefined.
- Assertion under simulation.

Optional Feature:
YSYX_22041752_WB_DEBUG_EN
- Defined: adds output ports
  - debug_wb_valid [LANES]: lane_valid & {LANES{ws_valid && ws_ready_go}}
  - debug_wb_pc [LANES*PC_WD]: captured PCs
  - debug_wb_commit [1]: ws_valid && ws_ready_go

  For difftest, one commit pulse per bundle.
- Undefined: ports and logic are absent; the rest of the behaviour is identical.

Test Plan:
1. LANES=2, WPORTS=2: bundle {x5=0x11, x6=0x22}, both valid -> both ports written in 1 cycle; ws_allowin stays 1; retire_cnt += 2.
2. LANES=2, WPORTS=1: same bundle -> port0 writes x5=0x11 in cycle 1 and x6=0x22 in cycle 2; ws_allowin = 0 in cycle 1; next bundle is accepted at the end of cycle 2; forward valid on both lanes in both cycles.
3. Same-rd conflict: lane0 x7=0xAA, lane1 x7=0xBB, WPORTS=2 -> only one write (x7=0xBB) in 1 cycle; both forward valids = 1.
4. x0 and we = 0 lanes: lane0 rd=0 we=1, lane1 we=0 -> no RF write; 1-cycle residency; forward valids = 0; retire_cnt += 2.
5. Single-lane bundle ms_to_ws_valid=2'b01 -> only lane 0 committed; retire_cnt += 1; lane 1 forward valid = 0.
6. Assert reset low mid-serialisation (WPORTS=1, after first write) -> next cycle all we = 0, ws_allowin = 1, retire_cnt = 0; a fresh bundle after release commits normally.

Source files
------------

// File: rtl/ysyx_22041752_wbu_multi_if.sv
// Bundle/commit interface between the MEM stage, the multi-lane WBU and its consumers.
// Purely structural: carries the valid/allowin bundle handshake, RF write ports, forwarding and retire count.
// Optional difftest signals exist only when YSYX_22041752_WB_DEBUG_EN is defined.
interface ysyx_22041752_wbu_multi_if #(
  parameter int LANES      = 2,
  parameter int RF_WPORTS  = 1,
  parameter int RF_ADDR_WD = 5,
  parameter int RF_DATA_WD = 64,
  parameter int PC_WD      = 64
);
  localparam int LW = 1 + RF_ADDR_WD + RF_DATA_WD + PC_WD;
  localparam int PW = 1 + RF_ADDR_WD + RF_DATA_WD;
  localparam int FW = 1 + RF_DATA_WD + RF_ADDR_WD;

  logic                      ws_allowin;
  logic [LANES-1:0]          ms_to_ws_valid;
  logic [LANES*LW-1:0]       ms_to_ws_bus;
  logic [RF_WPORTS*PW-1:0]   ws_to_rf_bus;
  logic [LANES*FW-1:0]       ws_forward_bus;
  logic [63:0]               ws_retire_cnt;
`ifdef YSYX_22041752_WB_DEBUG_EN
  logic [LANES-1:0]          debug_wb_valid;
  logic [LANES*PC_WD-1:0]    debug_wb_pc;
  logic                      debug_wb_commit;

  modport master (
    input  ws_allowin, ws_to_rf_bus, ws_forward_bus, ws_retire_cnt,
    input  debug_wb_valid, debug_wb_pc, debug_wb_commit,
    output ms_to_ws_valid, ms_to_ws_bus
  );
  modport slave (
    output ws_allowin, ws_to_rf_bus, ws_forward_bus, ws_retire_cnt,
    output debug_wb_valid, debug_wb_pc, debug_wb_commit,
    input  ms_to_ws_valid, ms_to_ws_bus
  );
`else
  modport master (
    input  ws_allowin, ws_to_rf_bus, ws_forward_bus, ws_retire_cnt,
    output ms_to_ws_valid, ms_to_ws_bus
  );
  modport slave (
    output ws_allowin, ws_to_rf_bus, ws_forward_bus, ws_retire_cnt,
    input  ms_to_ws_valid, ms_to_ws_bus
  );
`endif
endinterface

// File: rtl/ysyx_22041752_wbu_multi.sv
// Multi-lane write-back stage: commits up to LANES results through RF_WPORTS register-file ports.
// Latency: bundle resides ceil(k/RF_WPORTS) cycles (min 1), k = pending writes after x0/we/same-rd filtering.
// Backpressure: ws_allowin drops while a bundle still needs more writes than ports; macro YSYX_22041752_WB_DEBUG_EN adds difftest outputs.
module ysyx_22041752_wbu_multi #(
  parameter int LANES      = 2,
  parameter int RF_WPORTS  = 1,
  parameter int RF_ADDR_WD = 5,
  parameter int RF_DATA_WD = 64,
  parameter int PC_WD      = 64
) (
  input logic clk,
  input logic reset,
  ysyx_22041752_wbu_multi_if.slave wb
);
  localparam int LW = 1 + RF_ADDR_WD + RF_DATA_WD + PC_WD;
  localparam int PW = 1 + RF_ADDR_WD + RF_DATA_WD;
  localparam int FW = 1 + RF_DATA_WD + RF_ADDR_WD;

  logic                                 r_ws_valid;
  logic [LANES-1:0]                     r_lane_valid;
  logic [LANES-1:0]                     r_pend;
  logic [63:0]                          r_retire_cnt;
  logic [LANES-1:0]                     r_we;
  logic [LANES-1:0][RF_ADDR_WD-1:0]     r_rd;
  logic [LANES-1:0][RF_DATA_WD-1:0]     r_data;

  logic [LANES-1:0]                     w_in_we;
  logic [LANES-1:0][RF_ADDR_WD-1:0]     w_in_rd;
  logic [LANES-1:0][RF_DATA_WD-1:0]     w_in_data;
  logic [LANES-1:0]                     w_in_pend;
  logic [LANES-1:0]                     w_cap_pend;
  logic [LANES-1:0]                     w_served;
  logic [RF_WPORTS*PW-1:0]              w_rf_bus;
  logic [LANES*FW-1:0]                  w_fwd_bus;
  logic [63:0]                          w_lane_cnt;
  int                                   w_pend_cnt;
  logic                                 w_ready_go;
  logic                                 w_allowin;
  logic                                 w_accept;
  logic                                 w_commit;

  assign w_ready_go = (w_pend_cnt <= RF_WPORTS);
  assign w_allowin  = !r_ws_valid || w_ready_go;
  assign w_accept   = (|wb.ms_to_ws_valid) && w_allowin;
  assign w_commit   = r_ws_valid && w_ready_go;

  // Unpack incoming lanes and build the pending mask; a younger lane with the same rd masks older ones.
  always_comb begin
    w_in_we   = '0;
    w_in_rd   = '0;
    w_in_data = '0;
    w_in_pend = '0;
    w_cap_pend = '0;
    for (int i = 0; i < LANES; i++) begin
      w_in_we[i]   = wb.ms_to_ws_bus[i*LW + LW - 1];
      w_in_rd[i]   = wb.ms_to_ws_bus[i*LW + PC_WD + RF_DATA_WD +: RF_ADDR_WD];
      w_in_data[i] = wb.ms_to_ws_bus[i*LW + PC_WD +: RF_DATA_WD];
      w_in_pend[i] = wb.ms_to_ws_valid[i] && w_in_we[i] && (w_in_rd[i] != '0);
    end
    for (int i = 0; i < LANES; i++) begin
      w_cap_pend[i] = w_in_pend[i];
      for (int j = i + 1; j < LANES; j++) begin
        if (w_in_pend[j] && (w_in_rd[j] == w_in_rd[i])) w_cap_pend[i] = 1'b0;
      end
    end
  end

  // Hand the lowest-indexed pending lanes to ports 0.. in ascending order.
  always_comb begin
    int v_port;
    v_port     = 0;
    w_pend_cnt = 0;
    w_served   = '0;
    w_rf_bus   = '0;
    for (int i = 0; i < LANES; i++) begin
      if (r_pend[i]) w_pend_cnt = w_pend_cnt + 1;
    end
    for (int i = 0; i < LANES; i++) begin
      if (r_ws_valid && r_pend[i] && (v_port < RF_WPORTS)) begin
        w_rf_bus[v_port*PW +: PW] = {1'b1, r_rd[i], r_data[i]};
        w_served[i] = 1'b1;
        v_port = v_port + 1;
      end
    end
  end

  // Forwarding covers every writing lane for the whole residency, already-written or conflict-masked alike.
  always_comb begin
    w_fwd_bus  = '0;
    w_lane_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      w_fwd_bus[i*FW +: FW] = {r_ws_valid && r_lane_valid[i] && r_we[i] && (r_rd[i] != '0),
                               r_data[i], r_rd[i]};
      w_lane_cnt = w_lane_cnt + 64'(r_lane_valid[i]);
    end
  end

  // Control state: accept on allowin, retire pending bits as they are written, count on completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ws_valid   <= 1'b0;
      r_lane_valid <= '0;
      r_pend       <= '0;
      r_retire_cnt <= '0;
    end else begin
      if (w_allowin) begin
        r_ws_valid   <= |wb.ms_to_ws_valid;
        r_lane_valid <= wb.ms_to_ws_valid;
        r_pend       <= w_cap_pend;
      end else begin
        r_pend <= r_pend & ~w_served;
      end
      if (w_commit) r_retire_cnt <= r_retire_cnt + w_lane_cnt;
    end
  end

  // Bundle payload is only meaningful under r_ws_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we   <= w_in_we;
      r_rd   <= w_in_rd;
      r_data <= w_in_data;
    end
  end

  assign wb.ws_allowin     = w_allowin;
  assign wb.ws_to_rf_bus   = w_rf_bus;
  assign wb.ws_forward_bus = w_fwd_bus;
  assign wb.ws_retire_cnt  = r_retire_cnt;

`ifdef YSYX_22041752_WB_DEBUG_EN
  logic [LANES*PC_WD-1:0] r_pc;

  // Keep captured PCs for difftest reporting.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < LANES; i++) r_pc[i*PC_WD +: PC_WD] <= wb.ms_to_ws_bus[i*LW +: PC_WD];
    end
  end

  assign wb.debug_wb_valid  = r_lane_valid & {LANES{w_commit}};
  assign wb.debug_wb_pc     = r_pc;
  assign wb.debug_wb_commit = w_commit;
`endif

`ifndef SYNTHESIS
  logic [LANES-1:0] w_vld_p1;
  assign w_vld_p1 = wb.ms_to_ws_valid + LANES'(1);

  // Lane valids must be a contiguous run starting at lane 0.
  always @(posedge clk) begin
    if (reset) begin
      assert ((wb.ms_to_ws_valid & w_vld_p1) == '0)
        else $error("wbu_multi: non-contiguous ms_to_ws_valid %b", wb.ms_to_ws_valid);
    end
  end
`endif
endmodule

// File: tb/tb_ysyx_22041752_wbu_multi.sv
// Directed bench: one 2-lane/2-port and one 2-lane/1-port WBU driven side by side.
// Checks RF ports, forwarding, allowin and retire count against hand-computed values.
// Covers parallel commit, serialisation, same-rd conflict, x0/we=0 lanes, single lane, reset mid-commit.
module tb_ysyx_22041752_wbu_multi;
  localparam int A  = 5;
  localparam int D  = 64;
  localparam int PW = 1 + A + D;
  localparam int FW = 1 + D + A;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  ysyx_22041752_wbu_multi_if #(.LANES(2), .RF_WPORTS(2)) ifa ();
  ysyx_22041752_wbu_multi_if #(.LANES(2), .RF_WPORTS(1)) ifb ();

  ysyx_22041752_wbu_multi #(.LANES(2), .RF_WPORTS(2)) u_a (.clk(clk), .reset(reset), .wb(ifa));
  ysyx_22041752_wbu_multi #(.LANES(2), .RF_WPORTS(1)) u_b (.clk(clk), .reset(reset), .wb(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [267:0] mk_bus(input logic we1, input logic [4:0] rd1, input logic [63:0] d1,
                                          input logic we0, input logic [4:0] rd0, input logic [63:0] d0);
    return {we1, rd1, d1, 64'h8000_1004, we0, rd0, d0, 64'h8000_1000};
  endfunction

  function automatic logic [63:0] rf_we(input logic [2*PW-1:0] bus, input int p);
    return 64'(bus[p*PW + PW - 1]);
  endfunction
  function automatic logic [63:0] rf_addr(input logic [2*PW-1:0] bus, input int p);
    return 64'(bus[p*PW + D +: A]);
  endfunction
  function automatic logic [63:0] rf_data(input logic [2*PW-1:0] bus, input int p);
    return bus[p*PW +: D];
  endfunction
  function automatic logic [63:0] fw_vld(input logic [2*FW-1:0] bus, input int i);
    return 64'(bus[i*FW + FW - 1]);
  endfunction
  function automatic logic [63:0] fw_data(input logic [2*FW-1:0] bus, input int i);
    return bus[i*FW + A +: D];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2*PW-1:0] rb;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    ifa.ms_to_ws_valid = '0;
    ifa.ms_to_ws_bus   = '0;
    ifb.ms_to_ws_valid = '0;
    ifb.ms_to_ws_bus   = '0;
    rb = '0;

    // Reset state
    #2;
    chk("rst_a_allowin", 64'(ifa.ws_allowin), 64'd1);
    chk("rst_b_allowin", 64'(ifb.ws_allowin), 64'd1);
    chk("rst_a_we0",     rf_we(ifa.ws_to_rf_bus, 0), 64'd0);
    chk("rst_a_we1",     rf_we(ifa.ws_to_rf_bus, 1), 64'd0);
    chk("rst_a_fw0",     fw_vld(ifa.ws_forward_bus, 0), 64'd0);
    chk("rst_a_ret",     ifa.ws_retire_cnt, 64'd0);
    chk("rst_b_ret",     ifb.ws_retire_cnt, 64'd0);
    #1 reset = 1'b1;

    // Cycle 0: same two-write bundle into both instances
    tick();
    ifa.ms_to_ws_valid = 2'b11;
    ifa.ms_to_ws_bus   = mk_bus(1'b1, 5'd6, 64'h22, 1'b1, 5'd5, 64'h11);
    ifb.ms_to_ws_valid = 2'b11;
    ifb.ms_to_ws_bus   = mk_bus(1'b1, 5'd6, 64'h22, 1'b1, 5'd5, 64'h11);

    // Cycle 1: A writes both, B writes x5 and stalls; present next bundles
    tick();
    ifa.ms_to_ws_bus   = mk_bus(1'b1, 5'd7, 64'hBB, 1'b1, 5'd7, 64'hAA);
    ifb.ms_to_ws_valid = 2'b01;
    ifb.ms_to_ws_bus   = mk_bus(1'b1, 5'd10, 64'hAB, 1'b1, 5'd9, 64'h99);
    #1;
    chk("t1_a_we0",    rf_we(ifa.ws_to_rf_bus, 0), 64'd1);
    chk("t1_a_addr0",  rf_addr(ifa.ws_to_rf_bus, 0), 64'd5);
    chk("t1_a_data0",  rf_data(ifa.ws_to_rf_bus, 0), 64'h11);
    chk("t1_a_we1",    rf_we(ifa.ws_to_rf_bus, 1), 64'd1);
    chk("t1_a_addr1",  rf_addr(ifa.ws_to_rf_bus, 1), 64'd6);
    chk("t1_a_data1",  rf_data(ifa.ws_to_rf_bus, 1), 64'h22);
    chk("t1_a_allowin", 64'(ifa.ws_allowin), 64'd1);
    chk("t1_a_ret",    ifa.ws_retire_cnt, 64'd0);
    rb = {70'b0, ifb.ws_to_rf_bus};
    chk("t2_b_c1_we",   rf_we(rb, 0), 64'd1);
    chk("t2_b_c1_addr", rf_addr(rb, 0), 64'd5);
    chk("t2_b_c1_data", rf_data(rb, 0), 64'h11);
    chk("t2_b_c1_allowin", 64'(ifb.ws_allowin), 64'd0);
    chk("t2_b_c1_fw0",  fw_vld(ifb.ws_forward_bus, 0), 64'd1);
    chk("t2_b_c1_fw1",  fw_vld(ifb.ws_forward_bus, 1), 64'd1);
    chk("t2_b_c1_fwd1", fw_data(ifb.ws_forward_bus, 1), 64'h22);

    // Cycle 2: A holds the conflict bundle, B writes x6; A offered the x0/we=0 bundle
    tick();
    ifa.ms_to_ws_bus = mk_bus(1'b0, 5'd8, 64'h44, 1'b1, 5'd0, 64'h33);
    #1;
    chk("t1_a_ret2",   ifa.ws_retire_cnt, 64'd2);
    chk("t3_a_we0",    rf_we(ifa.ws_to_rf_bus, 0), 64'd1);
    chk("t3_a_addr0",  rf_addr(ifa.ws_to_rf_bus, 0), 64'd7);
    chk("t3_a_data0",  rf_data(ifa.ws_to_rf_bus, 0), 64'hBB);
    chk("t3_a_we1",    rf_we(ifa.ws_to_rf_bus, 1), 64'd0);
    chk("t3_a_fw0",    fw_vld(ifa.ws_forward_bus, 0), 64'd1);
    chk("t3_a_fw1",    fw_vld(ifa.ws_forward_bus, 1), 64'd1);
    chk("t3_a_fwd0",   fw_data(ifa.ws_forward_bus, 0), 64'hAA);
    chk("t3_a_allowin", 64'(ifa.ws_allowin), 64'd1);
    rb = {70'b0, ifb.ws_to_rf_bus};
    chk("t2_b_c2_we",   rf_we(rb, 0), 64'd1);
    chk("t2_b_c2_addr", rf_addr(rb, 0), 64'd6);
    chk("t2_b_c2_data", rf_data(rb, 0), 64'h22);
    chk("t2_b_c2_allowin", 64'(ifb.ws_allowin), 64'd1);
    chk("t2_b_c2_fw0",  fw_vld(ifb.ws_forward_bus, 0), 64'd1);
    chk("t2_b_c2_fw1",  fw_vld(ifb.ws_forward_bus, 1), 64'd1);
    chk("t2_b_c2_ret",  ifb.ws_retire_cnt, 64'd0);

    // Cycle 3: A no-write bundle, B single-lane bundle; B offered the bundle to be cut by reset
    tick();
    ifa.ms_to_ws_valid = 2'b00;
    ifb.ms_to_ws_valid = 2'b11;
    ifb.ms_to_ws_bus   = mk_bus(1'b1, 5'd6, 64'h66, 1'b1, 5'd5, 64'h55);
    #1;
    chk("t3_a_ret",    ifa.ws_retire_cnt, 64'd4);
    chk("t4_a_we0",    rf_we(ifa.ws_to_rf_bus, 0), 64'd0);
    chk("t4_a_we1",    rf_we(ifa.ws_to_rf_bus, 1), 64'd0);
    chk("t4_a_fw0",    fw_vld(ifa.ws_forward_bus, 0), 64'd0);
    chk("t4_a_fw1",    fw_vld(ifa.ws_forward_bus, 1), 64'd0);
    chk("t4_a_allowin", 64'(ifa.ws_allowin), 64'd1);
    rb = {70'b0, ifb.ws_to_rf_bus};
    chk("t2_b_ret",    ifb.ws_retire_cnt, 64'd2);
    chk("t5_b_we",     rf_we(rb, 0), 64'd1);
    chk("t5_b_addr",   rf_addr(rb, 0), 64'd9);
    chk("t5_b_data",   rf_data(rb, 0), 64'h99);
    chk("t5_b_allowin", 64'(ifb.ws_allowin), 64'd1);
    chk("t5_b_fw0",    fw_vld(ifb.ws_forward_bus, 0), 64'd1);
    chk("t5_b_fw1",    fw_vld(ifb.ws_forward_bus, 1), 64'd0);

    // Cycle 4: B serialising, first write; then reset pulled mid-cycle
    tick();
    ifb.ms_to_ws_valid = 2'b00;
    #1;
    chk("t4_a_ret",    ifa.ws_retire_cnt, 64'd6);
    chk("t5_b_ret",    ifb.ws_retire_cnt, 64'd3);
    rb = {70'b0, ifb.ws_to_rf_bus};
    chk("t6_b_we_pre",   rf_we(rb, 0), 64'd1);
    chk("t6_b_addr_pre", rf_addr(rb, 0), 64'd5);
    chk("t6_b_allow_pre", 64'(ifb.ws_allowin), 64'd0);
    #1 reset = 1'b0;
    #1;
    rb = {70'b0, ifb.ws_to_rf_bus};
    chk("t6_b_we_rst",    rf_we(rb, 0), 64'd0);
    chk("t6_b_allow_rst", 64'(ifb.ws_allowin), 64'd1);
    chk("t6_b_ret_rst",   ifb.ws_retire_cnt, 64'd0);
    chk("t6_b_fw0_rst",   fw_vld(ifb.ws_forward_bus, 0), 64'd0);
    chk("t6_a_ret_rst",   ifa.ws_retire_cnt, 64'd0);
    #1 reset = 1'b1;

    // Cycle 5: abandoned bundle is gone; offer a fresh one
    tick();
    rb = {70'b0, ifb.ws_to_rf_bus};
    chk("t6_b_we_idle", rf_we(rb, 0), 64'd0);
    chk("t6_b_ret_idle", ifb.ws_retire_cnt, 64'd0);
    ifb.ms_to_ws_valid = 2'b11;
    ifb.ms_to_ws_bus   = mk_bus(1'b1, 5'd6, 64'h88, 1'b1, 5'd5, 64'h77);

    // Cycle 6: first write of fresh bundle
    tick();
    ifb.ms_to_ws_valid = 2'b00;
    #1;
    rb = {70'b0, ifb.ws_to_rf_bus};
    chk("t6_b_f1_we",   rf_we(rb, 0), 64'd1);
    chk("t6_b_f1_addr", rf_addr(rb, 0), 64'd5);
    chk("t6_b_f1_data", rf_data(rb, 0), 64'h77);
    chk("t6_b_f1_allowin", 64'(ifb.ws_allowin), 64'd0);

    // Cycle 7: second write
    tick();
    #1;
    rb = {70'b0, ifb.ws_to_rf_bus};
    chk("t6_b_f2_we",   rf_we(rb, 0), 64'd1);
    chk("t6_b_f2_addr", rf_addr(rb, 0), 64'd6);
    chk("t6_b_f2_data", rf_data(rb, 0), 64'h88);
    chk("t6_b_f2_allowin", 64'(ifb.ws_allowin), 64'd1);
    chk("t6_b_f2_ret",  ifb.ws_retire_cnt, 64'd0);

    // Cycle 8: fresh bundle retired, stage idle
    tick();
    #1;
    rb = {70'b0, ifb.ws_to_rf_bus};
    chk("t6_b_f3_ret",  ifb.ws_retire_cnt, 64'd2);
    chk("t6_b_f3_we",   rf_we(rb, 0), 64'd0);
    chk("t6_b_f3_allowin", 64'(ifb.ws_allowin), 64'd1);
    chk("t6_b_f3_fw0",  fw_vld(ifb.ws_forward_bus, 0), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
